// File: rtl/uart_reg_cmd_parser.sv
// uart_reg_cmd_parser
//   ASCII register-access command parser between a UART RX FIFO and TX FIFO.
//   Decodes "Raa<EOL>" and "Waadd<EOL>" (hex), issues one-cycle read/write
//   strobes on a simple register bus and pushes a 4-byte reply:
//   "OK\r\n", "dd\r\n" (read data, uppercase hex) or "ER\r\n".
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   rx_empty/rx_data      RX FIFO status and head byte; rx_pop consumes it
//   tx_full               TX FIFO full; tx_data/tx_push write one byte
//   reg_addr/reg_wdata    register bus address and write data (held)
//   reg_we/reg_re         one-cycle write/read strobes
//   reg_rdata             read data, sampled the cycle after reg_re
//   busy                  high whenever the parser is not idle
//   cmd_err               one-cycle pulse when an ER reply is scheduled
module uart_reg_cmd_parser #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rx_pop,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_push,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        DISCARD,
        EXEC,
        RDWAIT,
        RESP
    } state_t;

    state_t              state_q;
    logic                is_wr_q;
    logic [2:0]          cnt_q;
    logic [15:0]         shift_q;
    logic [7:0]          b0_q;
    logic [7:0]          b1_q;
    logic [1:0]          idx_q;
    logic [ADDR_W-1:0]   reg_addr_q;
    logic [7:0]          reg_wdata_q;
    logic                reg_we_q;
    logic                reg_re_q;
    logic                cmd_err_q;

    logic                rx_eol;
    logic                rx_hex;
    logic                rx_is_r;
    logic                rx_is_w;
    logic [3:0]          rx_nib;
    logic [2:0]          cnt_max;
    logic [15:0]         shift_d;
    logic [7:0]          addr_d;
    logic [7:0]          wdata_d;

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return c[3:0];
        else
            return c[3:0] + 4'd9;   // 'A'/'a' have low nibble 1
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return {4'h3, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        rx_eol  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        rx_hex  = (rx_data >= 8'h30 && rx_data <= 8'h39) ||
                  (rx_data >= 8'h41 && rx_data <= 8'h46) ||
                  (rx_data >= 8'h61 && rx_data <= 8'h66);
        rx_is_r = (rx_data == 8'h52) || (rx_data == 8'h72);
        rx_is_w = (rx_data == 8'h57) || (rx_data == 8'h77);
        rx_nib  = hex_val(rx_data);
        cnt_max = is_wr_q ? 3'd4 : 3'd2;
        shift_d = {shift_q[11:0], rx_nib};
        // Address is the first two digits: high byte for W, low byte for R.
        addr_d  = is_wr_q ? shift_q[15:8] : shift_q[7:0];
        wdata_d = shift_q[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            idx_q       <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            reg_we_q  <= 1'b0;
            reg_re_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_empty && !rx_eol) begin
                        if (rx_is_r || rx_is_w) begin
                            is_wr_q <= rx_is_w;
                            cnt_q   <= '0;
                            shift_q <= '0;
                            state_q <= ARG;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end
                end
                ARG: begin
                    if (!rx_empty) begin
                        if (rx_hex) begin
                            if (cnt_q == cnt_max) begin
                                state_q <= DISCARD;
                            end else begin
                                shift_q <= shift_d;
                                cnt_q   <= cnt_q + 3'd1;
                            end
                        end else if (rx_eol) begin
                            if (cnt_q == cnt_max) begin
                                reg_addr_q <= addr_d[ADDR_W-1:0];
                                if (is_wr_q) begin
                                    reg_wdata_q <= wdata_d;
                                    reg_we_q    <= 1'b1;
                                end else begin
                                    reg_re_q    <= 1'b1;
                                end
                                state_q <= EXEC;
                            end else begin
                                b0_q      <= 8'h45;
                                b1_q      <= 8'h52;
                                idx_q     <= '0;
                                cmd_err_q <= 1'b1;
                                state_q   <= RESP;
                            end
                        end else begin
                            state_q <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (!rx_empty && rx_eol) begin
                        b0_q      <= 8'h45;
                        b1_q      <= 8'h52;
                        idx_q     <= '0;
                        cmd_err_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                EXEC: begin
                    if (is_wr_q) begin
                        b0_q    <= 8'h4F;
                        b1_q    <= 8'h4B;
                        idx_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    b0_q    <= to_ascii(reg_rdata[7:4]);
                    b1_q    <= to_ascii(reg_rdata[3:0]);
                    idx_q   <= '0;
                    state_q <= RESP;
                end
                RESP: begin
                    if (!tx_full) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    tx_data = b0_q;
            2'd1:    tx_data = b1_q;
            2'd2:    tx_data = 8'h0D;
            default: tx_data = 8'h0A;
        endcase
    end

    assign rx_pop    = !rx_empty && (state_q == IDLE || state_q == ARG || state_q == DISCARD);
    assign tx_push   = (state_q == RESP) && !tx_full;
    assign busy      = (state_q != IDLE);
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_reg_cmd_parser.sv
module tb_uart_reg_cmd_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_pop;
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_push;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       cmd_err;

    int vectors = 0;
    int miscompares = 0;

    uart_reg_cmd_parser #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rx_pop    (rx_pop),
        .tx_full   (tx_full),
        .tx_data   (tx_data),
        .tx_push   (tx_push),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // RX FIFO model: bench writes bytes, DUT pops them.
    logic [7:0] rx_buf [0:255];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    assign rx_empty = (rd_ptr == wr_ptr);
    assign rx_data  = rx_buf[rd_ptr];

    // Bus / TX monitor
    int         cyc = 0;
    int         eol_cyc = 0;
    logic [7:0] tx_log [0:63];
    int         tx_cyc [0:63];
    int         tx_n = 0;
    int         we_n = 0, re_n = 0, both_n = 0, err_n = 0, busy_n = 0;
    int         we_cyc = 0, re_cyc = 0, err_cyc = 0;
    logic [7:0] we_addr = '0, we_data = '0, re_addr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_pop) begin
            rd_ptr <= rd_ptr + 8'd1;
            if (rx_data == 8'h0D || rx_data == 8'h0A) eol_cyc <= cyc;
        end
        if (tx_push) begin
            tx_log[tx_n] <= tx_data;
            tx_cyc[tx_n] <= cyc;
            tx_n <= tx_n + 1;
        end
        if (reg_we) begin
            we_n <= we_n + 1; we_cyc <= cyc; we_addr <= reg_addr; we_data <= reg_wdata;
        end
        if (reg_re) begin
            re_n <= re_n + 1; re_cyc <= cyc; re_addr <= reg_addr;
        end
        if (reg_we && reg_re) both_n <= both_n + 1;
        if (cmd_err) begin err_n <= err_n + 1; err_cyc <= cyc; end
        if (busy) busy_n <= busy_n + 1;
    end

    task automatic send(input string s);
        @(negedge clk);
        for (int i = 0; i < s.len(); i++) begin
            rx_buf[wr_ptr] = s[i];
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!(rx_empty && !busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL %s: timeout waiting for idle (rx_empty=%0b busy=%0b)", name, rx_empty, busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_full = 1'b0; reg_rdata = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rx_pop, tx_push, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, cmd_err} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rx_pop, tx_push, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, cmd_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int base = tx_n;
        int wn = we_n;
        int rn = re_n;
        logic [7:0] exp [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        send("W3A5C\r");
        wait_done("write");
        vectors++;
        if (we_n - wn !== 1 || re_n !== rn) begin
            miscompares++;
            $display("FAIL write_strobe: we pulses %0d re pulses %0d required 1 and 0", we_n - wn, re_n - rn);
        end
        vectors++;
        if (we_addr !== 8'h3A || we_data !== 8'h5C) begin
            miscompares++;
            $display("FAIL write_bus: addr %h data %h required 3a 5c", we_addr, we_data);
        end
        vectors++;
        if (we_cyc !== eol_cyc + 1 || tx_cyc[base] !== eol_cyc + 2) begin
            miscompares++;
            $display("FAIL write_timing: we at T+%0d push at T+%0d required T+1 T+2",
                     we_cyc - eol_cyc, tx_cyc[base] - eol_cyc);
        end
        vectors++;
        if (tx_n - base !== 4) begin
            miscompares++;
            $display("FAIL write_count: %0d bytes required 4", tx_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (tx_log[base+k] !== exp[k]) begin
                miscompares++;
                $display("FAIL write_byte%0d: got %h required %h", k, tx_log[base+k], exp[k]);
            end
        end
        vectors++;
        if (reg_addr !== 8'h3A || reg_wdata !== 8'h5C) begin
            miscompares++;
            $display("FAIL write_hold: addr %h wdata %h required 3a 5c", reg_addr, reg_wdata);
        end
    endtask

    task automatic test_read();
        int base = tx_n;
        int rn = re_n;
        int wn = we_n;
        logic [7:0] exp [4] = '{8'h45, 8'h37, 8'h0D, 8'h0A};
        reg_rdata = 8'hE7;
        send("r3a\n");
        wait_done("read");
        vectors++;
        if (re_n - rn !== 1 || we_n !== wn || re_addr !== 8'h3A) begin
            miscompares++;
            $display("FAIL read_strobe: re pulses %0d we pulses %0d addr %h required 1 0 3a",
                     re_n - rn, we_n - wn, re_addr);
        end
        vectors++;
        if (re_cyc !== eol_cyc + 1 || tx_cyc[base] !== eol_cyc + 3) begin
            miscompares++;
            $display("FAIL read_timing: re at T+%0d push at T+%0d required T+1 T+3",
                     re_cyc - eol_cyc, tx_cyc[base] - eol_cyc);
        end
        vectors++;
        if (tx_n - base !== 4) begin
            miscompares++;
            $display("FAIL read_count: %0d bytes required 4", tx_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (tx_log[base+k] !== exp[k]) begin
                miscompares++;
                $display("FAIL read_byte%0d: got %h required %h", k, tx_log[base+k], exp[k]);
            end
        end
    endtask

    task automatic test_errors();
        string cmds [4] = '{"X12\r", "W12\r", "R1G\r", "R123\r"};
        logic [7:0] exp [4] = '{8'h45, 8'h52, 8'h0D, 8'h0A};
        for (int c = 0; c < 4; c++) begin
            int base = tx_n;
            int en = err_n;
            int wn = we_n;
            int rn = re_n;
            send(cmds[c]);
            wait_done("error");
            vectors++;
            if (err_n - en !== 1 || we_n !== wn || re_n !== rn) begin
                miscompares++;
                $display("FAIL err%0d_pulses: cmd_err %0d we %0d re %0d required 1 0 0",
                         c, err_n - en, we_n - wn, re_n - rn);
            end
            vectors++;
            if (err_cyc !== eol_cyc + 1 || tx_cyc[base] !== eol_cyc + 1) begin
                miscompares++;
                $display("FAIL err%0d_timing: cmd_err at T+%0d push at T+%0d required T+1 T+1",
                         c, err_cyc - eol_cyc, tx_cyc[base] - eol_cyc);
            end
            vectors++;
            if (tx_n - base !== 4) begin
                miscompares++;
                $display("FAIL err%0d_count: %0d bytes required 4", c, tx_n - base);
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (tx_log[base+k] !== exp[k]) begin
                    miscompares++;
                    $display("FAIL err%0d_byte%0d: got %h required %h", c, k, tx_log[base+k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_eol_only();
        int base = tx_n;
        int bn = busy_n;
        int sn = we_n + re_n + err_n;
        send("\r\n\r");
        repeat (6) @(negedge clk);
        vectors++;
        if (!rx_empty || tx_n !== base || busy_n !== bn || (we_n + re_n + err_n) !== sn) begin
            miscompares++;
            $display("FAIL eol_only: rx_empty %0b pushes %0d busy cycles %0d strobes %0d required 1 0 0 0",
                     rx_empty, tx_n - base, busy_n - bn, we_n + re_n + err_n - sn);
        end
    endtask

    task automatic test_back_to_back_full();
        int base = tx_n;
        int n = 0;
        logic [7:0] exp [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        send("W0102\r");
        while (tx_n - base < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_full = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (tx_n - base !== 1 || !busy) begin
            miscompares++;
            $display("FAIL full_stall: %0d bytes busy %0b required 1 1", tx_n - base, busy);
        end
        tx_full = 1'b0;
        wait_done("full");
        vectors++;
        if (tx_n - base !== 4 || we_addr !== 8'h01 || we_data !== 8'h02) begin
            miscompares++;
            $display("FAIL full_count: %0d bytes addr %h data %h required 4 01 02",
                     tx_n - base, we_addr, we_data);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (tx_log[base+k] !== exp[k]) begin
                miscompares++;
                $display("FAIL full_byte%0d: got %h required %h", k, tx_log[base+k], exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid_reply();
        int base = tx_n;
        int n = 0;
        logic [7:0] exp [4] = '{8'h30, 8'h39, 8'h0D, 8'h0A};
        send("W3A5C\r");
        while (tx_n - base < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rx_pop, tx_push, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, cmd_err} !== 29'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h required 0",
                     {rx_pop, tx_push, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, cmd_err});
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (tx_n - base !== 2) begin
            miscompares++;
            $display("FAIL midreset_abort: %0d bytes required 2", tx_n - base);
        end
        base = tx_n;
        reg_rdata = 8'h09;
        send("R00\r");
        wait_done("after_reset");
        vectors++;
        if (tx_n - base !== 4 || re_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL after_reset_count: %0d bytes addr %h required 4 00", tx_n - base, re_addr);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (tx_log[base+k] !== exp[k]) begin
                miscompares++;
                $display("FAIL after_reset_byte%0d: got %h required %h", k, tx_log[base+k], exp[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_eol_only();
        test_back_to_back_full();
        test_reset_mid_reply();
        vectors++;
        if (both_n !== 0) begin
            miscompares++;
            $display("FAIL we_re_overlap: %0d cycles required 0", both_n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
